// File: rtl/arcino_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arcino_pkg : shared write-back types and register-address sizing |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package arcino_pkg;

   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_SKID = 2'd1,
      WB_SRC_LSU  = 2'd2,
      WB_SRC_ALU  = 2'd3
   } wb_src_e;

   localparam int unsigned REG_ADDR_W = 5;

   function automatic int unsigned addr_width(input bit rv32e);
      return rv32e ? 4 : 5;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arcino_wb_skid.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arcino_wb_skid : one-entry holding register for a deferred result |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module arcino_wb_skid #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o
);

   logic          valid_q, valid_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic [DW-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (pop_i) begin
         valid_d = 1'b0;
      end
      if (push_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/arcino_wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arcino_wb_stage : ALU/LSU write-back arbiter with load scoreboard |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module arcino_wb_stage
   import arcino_pkg::*;
#(
   parameter bit          RV32E     = 1'b0,
   parameter int unsigned DataWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  alu_valid_i,
   output logic                  alu_ready_o,
   input  logic [4:0]            alu_waddr_i,
   input  logic [DataWidth-1:0]  alu_wdata_i,
   input  logic                  lsu_valid_i,
   output logic                  lsu_ready_o,
   input  logic [4:0]            lsu_waddr_i,
   input  logic [DataWidth-1:0]  lsu_wdata_i,
   input  logic                  load_issue_i,
   input  logic [4:0]            load_issue_addr_i,
   input  logic [4:0]            raddr_a_i,
   input  logic [4:0]            raddr_b_i,
   output logic                  hazard_a_o,
   output logic                  hazard_b_o,
   output logic                  rf_we_o,
   output logic [4:0]            rf_waddr_o,
   output logic [DataWidth-1:0]  rf_wdata_o
);

   localparam int unsigned ADDR_WIDTH = addr_width(RV32E);
   localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;

   logic                  skid_valid;
   logic [ADDR_WIDTH-1:0] skid_addr;
   logic [DataWidth-1:0]  skid_data;
   logic                  ready;
   logic                  alu_fire, lsu_fire;
   logic [ADDR_WIDTH-1:0] alu_addr, lsu_addr, issue_addr, ra_a, ra_b;
   wb_src_e               src;

   logic                  rf_we_q,    rf_we_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DataWidth-1:0]  rf_wdata_q, rf_wdata_d;
   logic [NUM_WORDS-1:0]  pending_q,  pending_d;

   assign alu_addr   = alu_waddr_i[ADDR_WIDTH-1:0];
   assign lsu_addr   = lsu_waddr_i[ADDR_WIDTH-1:0];
   assign issue_addr = load_issue_addr_i[ADDR_WIDTH-1:0];
   assign ra_a       = raddr_a_i[ADDR_WIDTH-1:0];
   assign ra_b       = raddr_b_i[ADDR_WIDTH-1:0];

   // Ready depends only on skid state, so valid never feeds back into ready.
   assign ready       = ~skid_valid;
   assign alu_ready_o = ready;
   assign lsu_ready_o = ready;
   assign alu_fire    = alu_valid_i & ready;
   assign lsu_fire    = lsu_valid_i & ready;

   arcino_wb_skid #(
      .AW (ADDR_WIDTH),
      .DW (DataWidth)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (alu_fire & lsu_fire),
      .pop_i   (skid_valid),
      .addr_i  (alu_addr),
      .data_i  (alu_wdata_i),
      .valid_o (skid_valid),
      .addr_o  (skid_addr),
      .data_o  (skid_data)
   );

   always_comb begin
      src = WB_SRC_NONE;
      if (skid_valid) begin
         src = WB_SRC_SKID;
      end else if (lsu_fire) begin
         src = WB_SRC_LSU;
      end else if (alu_fire) begin
         src = WB_SRC_ALU;
      end
   end

   always_comb begin
      rf_waddr_d = '0;
      rf_wdata_d = '0;
      case (src)
         WB_SRC_SKID: begin
            rf_waddr_d = skid_addr;
            rf_wdata_d = skid_data;
         end
         WB_SRC_LSU: begin
            rf_waddr_d = lsu_addr;
            rf_wdata_d = lsu_wdata_i;
         end
         WB_SRC_ALU: begin
            rf_waddr_d = alu_addr;
            rf_wdata_d = alu_wdata_i;
         end
         default: ;
      endcase
      // x0 results are consumed but never reach the register file.
      rf_we_d = (src != WB_SRC_NONE) && (rf_waddr_d != '0);
   end

   // Set is applied after clear so a same-cycle reissue stays pending.
   always_comb begin
      pending_d = pending_q;
      if (lsu_fire) begin
         pending_d[lsu_addr] = 1'b0;
      end
      if (load_issue_i) begin
         pending_d[issue_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         pending_q  <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         pending_q  <= pending_d;
      end
   end

   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = REG_ADDR_W'(rf_waddr_q);
   assign rf_wdata_o = rf_wdata_q;

   assign hazard_a_o = (ra_a != '0) &&
                       (pending_q[ra_a] ||
                        (skid_valid && (skid_addr == ra_a)) ||
                        (rf_we_q && (rf_waddr_q == ra_a)));
   assign hazard_b_o = (ra_b != '0) &&
                       (pending_q[ra_b] ||
                        (skid_valid && (skid_addr == ra_b)) ||
                        (rf_we_q && (rf_waddr_q == ra_b)));

endmodule
`default_nettype wire

// File: tb/tb_arcino_wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_arcino_wb_stage : randomized bench with behavioural reference  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_arcino_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0, lsu_valid = 1'b0, load_issue = 1'b0;
   logic [4:0]  alu_waddr = '0, lsu_waddr = '0, load_issue_addr = '0;
   logic [4:0]  raddr_a = '0, raddr_b = '0;
   logic [31:0] alu_wdata = '0, lsu_wdata = '0;

   logic        alu_ready, lsu_ready, hz_a, hz_b, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        alu_ready_e, lsu_ready_e, hz_a_e, hz_b_e, rf_we_e;
   logic [4:0]  rf_waddr_e;
   logic [31:0] rf_wdata_e;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   arcino_wb_stage #(.RV32E(1'b0), .DataWidth(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
      .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
      .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
      .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
      .load_issue_i(load_issue), .load_issue_addr_i(load_issue_addr),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .hazard_a_o(hz_a), .hazard_b_o(hz_b),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
   );

   arcino_wb_stage #(.RV32E(1'b1), .DataWidth(32)) dut_e (
      .clk_i(clk), .rst_i(rst),
      .alu_valid_i(alu_valid), .alu_ready_o(alu_ready_e),
      .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
      .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready_e),
      .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
      .load_issue_i(load_issue), .load_issue_addr_i(load_issue_addr),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .hazard_a_o(hz_a_e), .hazard_b_o(hz_b_e),
      .rf_we_o(rf_we_e), .rf_waddr_o(rf_waddr_e), .rf_wdata_o(rf_wdata_e)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: results arriving at an edge form an ordered list; the head
   // is written next cycle and any leftover waits one cycle in the skid.
   typedef struct { logic [4:0] a; logic [31:0] d; } wb_t;
   wb_t         res_q[$];
   bit [31:0]   m_pend = '0;
   bit          m_sv = 1'b0, m_we = 1'b0;
   logic [4:0]  m_sa = '0, m_wa = '0;
   logic [31:0] m_sd = '0, m_wd = '0;
   bit          alu_took = 1'b0, lsu_took = 1'b0;

   always @(posedge clk) begin
      wb_t w;
      alu_took = 1'b0;
      lsu_took = 1'b0;
      if (rst) begin
         m_pend = '0; m_sv = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      end else begin
         res_q.delete();
         if (m_sv) begin
            res_q.push_back('{m_sa, m_sd});
         end else begin
            if (lsu_valid) begin res_q.push_back('{lsu_waddr, lsu_wdata}); lsu_took = 1'b1; end
            if (alu_valid) begin res_q.push_back('{alu_waddr, alu_wdata}); alu_took = 1'b1; end
         end
         if (lsu_took) m_pend[lsu_waddr] = 1'b0;
         if (load_issue && load_issue_addr != 5'd0) m_pend[load_issue_addr] = 1'b1;
         m_we = 1'b0;
         if (res_q.size() > 0) begin
            w = res_q.pop_front();
            m_we = (w.a != 5'd0);
            m_wa = w.a;
            m_wd = w.d;
         end
         m_sv = (res_q.size() > 0);
         if (m_sv) begin m_sa = res_q[0].a; m_sd = res_q[0].d; end
      end
   end

   function automatic bit exp_hz(input logic [4:0] ra);
      return (ra != 5'd0) && (m_pend[ra] || (m_sv && m_sa == ra) || (m_we && m_wa == ra));
   endfunction

   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         chk("alu_ready", {31'd0, alu_ready}, {31'd0, !m_sv});
         chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, !m_sv});
         chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
         if (m_we) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_wa});
            chk("rf_wdata", rf_wdata, m_wd);
         end
         chk("hazard_a", {31'd0, hz_a}, {31'd0, exp_hz(raddr_a)});
         chk("hazard_b", {31'd0, hz_b}, {31'd0, exp_hz(raddr_b)});
      end
   end

   task automatic idle();
      alu_valid = 1'b0; lsu_valid = 1'b0; load_issue = 1'b0; rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      #2;
      chk("rst_we", {31'd0, rf_we}, 32'd0);
      chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_ready", {30'd0, alu_ready, lsu_ready}, 32'd3);

      // ALU only
      @(negedge clk); alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
      @(negedge clk); idle(); #2;
      chk("alu_we", {31'd0, rf_we}, 32'd1);
      chk("alu_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
      @(negedge clk); #2;
      chk("alu_we_off", {31'd0, rf_we}, 32'd0);

      // Collision: LSU first, ALU through the skid
      @(negedge clk);
      lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h11;
      alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h22;
      @(negedge clk); idle(); #2;
      chk("col_first", {rf_we, 2'd0, rf_waddr, rf_wdata[23:0]}, {1'b1, 2'd0, 5'd3, 24'h11});
      chk("col_ready", {30'd0, alu_ready, lsu_ready}, 32'd0);
      @(negedge clk); #2;
      chk("col_second", {rf_we, 2'd0, rf_waddr, rf_wdata[23:0]}, {1'b1, 2'd0, 5'd7, 24'h22});
      chk("col_ready2", {30'd0, alu_ready, lsu_ready}, 32'd3);

      // Scoreboard on x9
      @(negedge clk); load_issue = 1'b1; load_issue_addr = 5'd9; raddr_a = 5'd9;
      @(negedge clk); idle(); #2;
      chk("sb_set", {31'd0, hz_a}, 32'd1);
      @(negedge clk); lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h99; #2;
      chk("sb_hold", {31'd0, hz_a}, 32'd1);
      @(negedge clk); idle(); #2;
      chk("sb_outstage", {31'd0, hz_a}, 32'd1);
      @(negedge clk); #2;
      chk("sb_clear", {31'd0, hz_a}, 32'd0);

      // x0 result consumed silently
      @(negedge clk); alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFFFFFF; raddr_b = 5'd0; #2;
      chk("x0_hz_b", {31'd0, hz_b}, 32'd0);
      chk("x0_ready", {31'd0, alu_ready}, 32'd1);
      @(negedge clk); idle(); #2;
      chk("x0_we", {31'd0, rf_we}, 32'd0);

      // Reset with skid occupied and x4 pending
      @(negedge clk);
      lsu_valid = 1'b1; lsu_waddr = 5'd1; lsu_wdata = 32'hA1;
      alu_valid = 1'b1; alu_waddr = 5'd2; alu_wdata = 32'hA2;
      load_issue = 1'b1; load_issue_addr = 5'd4;
      @(negedge clk); idle(); rst = 1'b1; raddr_a = 5'd4; #2;
      chk("pre_rst_ready", {31'd0, alu_ready}, 32'd0);
      chk("pre_rst_hz4", {31'd0, hz_a}, 32'd1);
      @(negedge clk); rst = 1'b0; #2;
      chk("post_rst_we", {31'd0, rf_we}, 32'd0);
      chk("post_rst_hz4", {31'd0, hz_a}, 32'd0);
      chk("post_rst_ready", {30'd0, alu_ready, lsu_ready}, 32'd3);

      // RV32E address truncation
      @(negedge clk); alu_valid = 1'b1; alu_waddr = 5'h13; alu_wdata = 32'h5;
      @(negedge clk); idle(); #2;
      chk("e_we", {31'd0, rf_we_e}, 32'd1);
      chk("e_waddr", {27'd0, rf_waddr_e}, 32'd3);
      chk("e_wdata", rf_wdata_e, 32'h5);

      // Randomized traffic; producers hold until the model sees a transfer
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (!alu_valid || alu_took || rst) begin
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_waddr = 5'($urandom_range(0, 7));
            alu_wdata = $urandom;
         end
         if (!lsu_valid || lsu_took || rst) begin
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_waddr = 5'($urandom_range(0, 7));
            lsu_wdata = $urandom;
         end
         load_issue      = ($urandom_range(0, 3) == 0);
         load_issue_addr = 5'($urandom_range(0, 7));
         raddr_a         = 5'($urandom_range(0, 7));
         raddr_b         = 5'($urandom_range(0, 7));
         rst             = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk); idle();
      @(negedge clk); #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
